rename_map: RTL and testbench

//  Register-rename stage: maps architectural rs1/rs2/rd to physical tags.

---
 rtl/rename_pkg.sv | 22 ++
 rtl/rename_ready_table.sv | 42 ++++
 rtl/rename_map.sv | 129 ++++++++++++
 tb/tb_rename_map.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared types and sizing for the register-rename slice.
package rename_pkg;

  localparam int ARCH_REGS = 32;
  localparam int AR_BITS   = 5;
  localparam int PHYS_REGS = 64;
  localparam int PR_BITS   = 6;

  typedef logic [PR_BITS-1:0] phys_tag_t;
  typedef logic [AR_BITS-1:0] arch_reg_t;

  typedef struct packed {
    phys_tag_t prs1;
    phys_tag_t prs2;
    logic      rdy1;
    logic      rdy2;
    phys_tag_t prd;
    phys_tag_t old_prd;
    logic      rd_we;
  } renamed_op_t;

endpackage

// File: rtl/rename_ready_table.sv
// Per-physical-tag ready bits: set on writeback, cleared on allocation, bulk-set on flush.
module rename_ready_table
  import rename_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [PR_BITS-1:0] wb_prd,
  input  logic               alloc_en,
  input  logic [PR_BITS-1:0] alloc_prd,
  input  logic [PR_BITS-1:0] rd_tag1,
  input  logic [PR_BITS-1:0] rd_tag2,
  output logic               rdy1,
  output logic               rdy2
);

  logic [PHYS_REGS-1:0] ready_q, ready_d;

  always_comb begin
    ready_d = ready_q;
    if (flush) begin
      ready_d = '1;
    end else begin
      if (wb_en)    ready_d[wb_prd]    = 1'b1;
      // Allocation after writeback so a recycled tag comes back not-ready.
      if (alloc_en) ready_d[alloc_prd] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= {{(PHYS_REGS-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
    end else begin
      ready_q <= ready_d;
    end
  end

  assign rdy1 = (rd_tag1 == '0) | ready_q[rd_tag1] | (wb_en & (wb_prd == rd_tag1));
  assign rdy2 = (rd_tag2 == '0) | ready_q[rd_tag2] | (wb_en & (wb_prd == rd_tag2));

endmodule

// File: rtl/rename_map.sv
// Rename stage: speculative/committed RATs, ready table and a one-deep output register.
module rename_map
  import rename_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AR_BITS-1:0] in_rs1,
  input  logic [AR_BITS-1:0] in_rs2,
  input  logic [AR_BITS-1:0] in_rd,
  input  logic               in_rd_we,
  output logic               fl_alloc_en,
  input  logic [PR_BITS-1:0] fl_alloc_reg,
  input  logic               fl_alloc_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PR_BITS-1:0] out_prs1,
  output logic [PR_BITS-1:0] out_prs2,
  output logic               out_rs1_rdy,
  output logic               out_rs2_rdy,
  output logic [PR_BITS-1:0] out_prd,
  output logic [PR_BITS-1:0] out_old_prd,
  output logic               out_rd_we,
  input  logic               wb_en,
  input  logic [PR_BITS-1:0] wb_prd,
  input  logic               commit_en,
  input  logic [AR_BITS-1:0] commit_rd,
  input  logic [PR_BITS-1:0] commit_prd
);

  phys_tag_t   spec_rat_q [ARCH_REGS];
  phys_tag_t   spec_rat_d [ARCH_REGS];
  phys_tag_t   comm_rat_q [ARCH_REGS];
  phys_tag_t   comm_rat_d [ARCH_REGS];
  renamed_op_t op_q, op_d, op_new;
  logic        out_valid_q, out_valid_d;
  logic        alloc_need, fire, alloc_en;
  logic        src_rdy1, src_rdy2;

  assign alloc_need  = in_rd_we & (in_rd != '0);
  assign in_ready    = ~flush & (~out_valid_q | out_ready) & (~alloc_need | fl_alloc_valid);
  assign fire        = in_valid & in_ready;
  assign alloc_en    = fire & alloc_need;
  assign fl_alloc_en = alloc_en;

  rename_ready_table u_ready (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_prd    (wb_prd),
    .alloc_en  (alloc_en),
    .alloc_prd (fl_alloc_reg),
    .rd_tag1   (spec_rat_q[in_rs1]),
    .rd_tag2   (spec_rat_q[in_rs2]),
    .rdy1      (src_rdy1),
    .rdy2      (src_rdy2)
  );

  always_comb begin
    comm_rat_d = comm_rat_q;
    if (commit_en && (commit_rd != '0)) comm_rat_d[commit_rd] = commit_prd;
  end

  // Flush restores the committed view including a commit landing the same cycle.
  always_comb begin
    spec_rat_d = spec_rat_q;
    if (flush) begin
      spec_rat_d = comm_rat_d;
    end else if (alloc_en) begin
      spec_rat_d[in_rd] = fl_alloc_reg;
    end
  end

  always_comb begin
    op_new.prs1    = spec_rat_q[in_rs1];
    op_new.prs2    = spec_rat_q[in_rs2];
    op_new.rdy1    = src_rdy1;
    op_new.rdy2    = src_rdy2;
    op_new.prd     = alloc_need ? fl_alloc_reg : '0;
    op_new.old_prd = spec_rat_q[in_rd];
    op_new.rd_we   = alloc_need;
  end

  always_comb begin
    op_d        = op_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      op_d        = op_new;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      // Held op snoops writebacks so issue never sees a stale not-ready.
      if (wb_en && (wb_prd == op_q.prs1)) op_d.rdy1 = 1'b1;
      if (wb_en && (wb_prd == op_q.prs2)) op_d.rdy2 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat_q[i] <= phys_tag_t'(i);
        comm_rat_q[i] <= phys_tag_t'(i);
      end
      op_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      spec_rat_q  <= spec_rat_d;
      comm_rat_q  <= comm_rat_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_prs1    = op_q.prs1;
  assign out_prs2    = op_q.prs2;
  assign out_rs1_rdy = op_q.rdy1;
  assign out_rs2_rdy = op_q.rdy2;
  assign out_prd     = op_q.prd;
  assign out_old_prd = op_q.old_prd;
  assign out_rd_we   = op_q.rd_we;

endmodule

// File: tb/tb_rename_map.sv
// Scoreboard bench for rename_map: array-based reference model, directed then random stimulus.
module tb_rename_map;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, in_valid, in_ready, in_rd_we;
  logic [AR_BITS-1:0] in_rs1, in_rs2, in_rd, commit_rd;
  logic fl_alloc_en, fl_alloc_valid, out_valid, out_ready;
  logic [PR_BITS-1:0] fl_alloc_reg, out_prs1, out_prs2, out_prd, out_old_prd, wb_prd, commit_prd;
  logic out_rs1_rdy, out_rs2_rdy, out_rd_we, wb_en, commit_en;

  always #5 clk = ~clk;

  rename_map dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .fl_alloc_en(fl_alloc_en), .fl_alloc_reg(fl_alloc_reg), .fl_alloc_valid(fl_alloc_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2),
    .out_rs1_rdy(out_rs1_rdy), .out_rs2_rdy(out_rs2_rdy),
    .out_prd(out_prd), .out_old_prd(out_old_prd), .out_rd_we(out_rd_we),
    .wb_en(wb_en), .wb_prd(wb_prd),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_prd(commit_prd)
  );

  typedef struct {
    logic      in_valid, rd_we, fl_valid, out_ready, flush, wb_en, commit_en;
    arch_reg_t rs1, rs2, rd, commit_rd;
    phys_tag_t fl_reg, wb_prd, commit_prd;
  } stim_t;

  // Reference model: plain arrays indexed by register number.
  phys_tag_t   m_spec [ARCH_REGS];
  phys_tag_t   m_comm [ARCH_REGS];
  bit          m_ready[PHYS_REGS];
  renamed_op_t sb[$];

  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.out_ready = 1'b1;
    s.fl_valid  = 1'b1;
    return s;
  endfunction

  function automatic stim_t op(input int rs1, input int rs2, input int rd, input bit we,
                               input int fl);
    stim_t s;
    s          = idle();
    s.in_valid = 1'b1;
    s.rs1      = arch_reg_t'(rs1);
    s.rs2      = arch_reg_t'(rs2);
    s.rd       = arch_reg_t'(rd);
    s.rd_we    = we;
    s.fl_reg   = phys_tag_t'(fl);
    return s;
  endfunction

  function automatic bit src_ready(input phys_tag_t p, input stim_t s);
    return (p == 0) || m_ready[p] || (s.wb_en && s.wb_prd == p);
  endfunction

  // One clock: drive, check handshake outputs, then advance the model at the edge.
  task automatic step(input stim_t s_in);
    stim_t       s;
    bit          need, exp_in_ready, fire;
    renamed_op_t e;
    s = s_in;
    if (s.flush) s.out_ready = 1'b0;
    flush = s.flush; in_valid = s.in_valid; in_rs1 = s.rs1; in_rs2 = s.rs2; in_rd = s.rd;
    in_rd_we = s.rd_we; fl_alloc_reg = s.fl_reg; fl_alloc_valid = s.fl_valid;
    out_ready = s.out_ready; wb_en = s.wb_en; wb_prd = s.wb_prd;
    commit_en = s.commit_en; commit_rd = s.commit_rd; commit_prd = s.commit_prd;
    #1;
    need         = s.rd_we && (s.rd != 0);
    exp_in_ready = !s.flush && (sb.size() == 0 || s.out_ready) && (!need || s.fl_valid);
    fire         = s.in_valid && exp_in_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready});
    chk("fl_alloc_en", {31'd0, fl_alloc_en}, {31'd0, fire && need});
    e.prs1    = m_spec[s.rs1];
    e.prs2    = m_spec[s.rs2];
    e.rdy1    = src_ready(e.prs1, s);
    e.rdy2    = src_ready(e.prs2, s);
    e.prd     = need ? s.fl_reg : '0;
    e.old_prd = m_spec[s.rd];
    e.rd_we   = need;
    @(posedge clk);
    if (s.commit_en && s.commit_rd != 0) m_comm[s.commit_rd] = s.commit_prd;
    if (s.flush) begin
      for (int i = 0; i < ARCH_REGS; i++) m_spec[i] = m_comm[i];
      for (int i = 0; i < PHYS_REGS; i++) m_ready[i] = 1'b1;
      sb.delete();
    end else begin
      if (s.wb_en) m_ready[s.wb_prd] = 1'b1;
      if (fire && need) begin
        m_spec[s.rd]     = s.fl_reg;
        m_ready[s.fl_reg] = 1'b0;
      end
      if (sb.size() != 0 && s.wb_en) begin
        if (sb[0].prs1 == s.wb_prd) sb[0].rdy1 = 1'b1;
        if (sb[0].prs2 == s.wb_prd) sb[0].rdy2 = 1'b1;
      end
      if (fire) sb.push_back(e);
    end
    #1;
  endtask

  // Monitor: checks occupancy every cycle and each consumed op against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      if (out_valid && out_ready && sb.size() != 0) begin
        renamed_op_t e;
        e = sb.pop_front();
        chk("out_prs1", 32'(out_prs1), 32'(e.prs1));
        chk("out_prs2", 32'(out_prs2), 32'(e.prs2));
        chk("out_rs1_rdy", {31'd0, out_rs1_rdy}, {31'd0, e.rdy1});
        chk("out_rs2_rdy", {31'd0, out_rs2_rdy}, {31'd0, e.rdy2});
        chk("out_prd", 32'(out_prd), 32'(e.prd));
        chk("out_old_prd", 32'(out_old_prd), 32'(e.old_prd));
        chk("out_rd_we", {31'd0, out_rd_we}, {31'd0, e.rd_we});
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0;
    fl_alloc_reg = 0; fl_alloc_valid = 0; out_ready = 0; wb_en = 0; wb_prd = 0;
    commit_en = 0; commit_rd = 0; commit_prd = 0;
    for (int i = 0; i < ARCH_REGS; i++) begin
      m_spec[i] = phys_tag_t'(i);
      m_comm[i] = phys_tag_t'(i);
    end
    for (int i = 0; i < PHYS_REGS; i++) m_ready[i] = (i < ARCH_REGS);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_prs1", 32'(out_prs1), 32'd0);
    chk("reset out_prd", 32'(out_prd), 32'd0);
    chk("reset out_old_prd", 32'(out_old_prd), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    step(op(1, 2, 3, 1, 32));                       // x3 <- x1,x2
    step(op(3, 3, 4, 1, 33));                       // dependent, both sources tag 32
    s = idle(); s.out_ready = 0; s.wb_en = 1; s.wb_prd = 32; step(s);  // held, wb pickup
    step(idle());
    step(op(1, 2, 0, 1, 50));                       // rd = x0: no alloc
    s = op(1, 2, 6, 1, 51); s.fl_valid = 0; step(s); // freelist empty: stall
    s = op(1, 2, 6, 0, 51); s.fl_valid = 0; step(s); // non-writing op still fires
    s = op(1, 1, 9, 1, 52); s.out_ready = 0; step(s); // output held: no fire
    step(idle());
    step(op(0, 0, 5, 1, 40));
    s = idle(); s.commit_en = 1; s.commit_rd = 5; s.commit_prd = 40; step(s);
    step(op(0, 0, 5, 1, 41));
    s = idle(); s.flush = 1; step(s);
    step(op(5, 5, 0, 0, 0));                        // x5 back to 40, ready
    step(op(0, 0, 7, 1, 36));
    s = op(7, 7, 0, 0, 0); s.wb_en = 1; s.wb_prd = 36; step(s);     // wb bypass on read
    s = op(0, 0, 8, 1, 36); s.wb_en = 1; s.wb_prd = 36; step(s);    // alloc beats wb
    step(op(8, 8, 0, 0, 0));
    step(idle());

    for (int n = 0; n < 600; n++) begin
      s            = idle();
      s.in_valid   = ($urandom_range(0, 3) != 0);
      s.rs1        = arch_reg_t'($urandom_range(0, 7));
      s.rs2        = arch_reg_t'($urandom_range(0, 31));
      s.rd         = arch_reg_t'($urandom_range(0, 7));
      s.rd_we      = ($urandom_range(0, 9) < 7);
      s.fl_reg     = phys_tag_t'($urandom_range(1, 63));
      s.fl_valid   = ($urandom_range(0, 9) != 0);
      s.out_ready  = ($urandom_range(0, 3) != 0);
      s.flush      = ($urandom_range(0, 39) == 0);
      s.wb_en      = ($urandom_range(0, 1) != 0);
      s.wb_prd     = phys_tag_t'($urandom_range(0, 63));
      s.commit_en  = ($urandom_range(0, 2) == 0);
      s.commit_rd  = arch_reg_t'($urandom_range(0, 7));
      s.commit_prd = phys_tag_t'($urandom_range(0, 63));
      step(s);
    end
    step(idle());
    step(idle());
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
